regfile_wb_arbiter: RTL

Shares the register file's single write port between NREQ writeback sources: load return, ALU result and multiply/divide result. Each source hands over a (destination, data) pair through a valid/ready handshake into a one-entry holding slot. Each cycle the arbiter grants at most one slot and drives the registered write port `d`/`rd`/`rwe`, which the register file samples on the falling edge. Fixed priority is backed by a starvation counter, so no source waits indefinitely.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_wb_slot.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants, writeback requester indices and the request payload type.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned WAIT_W     = 4;

  localparam int unsigned WB_LOAD   = 0;
  localparam int unsigned WB_ALU    = 1;
  localparam int unsigned WB_MULDIV = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_slot.sv
// One-entry writeback holding slot with a saturating wait counter used for starvation relief.
module regfile_wb_slot
  import regfile_pkg::*;
#(
  parameter int unsigned StarveLimit = 4
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  wb_req_t req_i,
  input  logic    grant_i,
  output logic    full_o,
  output wb_req_t entry_o,
  output logic    urgent_o
);

  logic              full_q, full_d;
  wb_req_t           entry_q, entry_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    wait_d  = wait_q;
    if (grant_i) begin
      full_d = 1'b0;
      wait_d = '0;
    end else if (full_q && (wait_q != '1)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
    // A push in the same cycle as a grant refills the slot behind the departing entry.
    if (push_i) begin
      full_d  = 1'b1;
      entry_d = req_i;
      wait_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q  <= 1'b0;
      entry_q <= '0;
      wait_q  <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
      wait_q  <= wait_d;
    end
  end

  assign full_o   = full_q;
  assign entry_o  = entry_q;
  assign urgent_o = full_q && (wait_q >= WAIT_W'(StarveLimit));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NREQ writeback slots onto the register file's single registered write port.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ         = 3,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*REG_ADDR_W-1:0] req_dest,
  input  logic [NREQ*REG_DATA_W-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic [REG_ADDR_W-1:0]      d,
  output logic [REG_DATA_W-1:0]      rd,
  output logic                       rwe,
  output logic                       busy
);

  logic [NREQ-1:0] full, urgent, grant, push;
  wb_req_t         slot_entry [NREQ];
  wb_req_t         slot_req   [NREQ];
  logic            found;

  logic [REG_ADDR_W-1:0] d_q, d_d;
  logic [REG_DATA_W-1:0] rd_q, rd_d;
  logic                  rwe_q, rwe_d;

  // Urgent slots pre-empt base priority; lowest index wins within each class.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (urgent[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (full[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Writes to r0 are handshaked but never occupy a slot.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i]     = !reset && (!full[i] || grant[i]);
      slot_req[i].dest = req_dest[REG_ADDR_W*i +: REG_ADDR_W];
      slot_req[i].data = req_data[REG_DATA_W*i +: REG_DATA_W];
      push[i]          = req_valid[i] && req_ready[i] && (slot_req[i].dest != '0);
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    regfile_wb_slot #(
      .StarveLimit(STARVE_LIMIT)
    ) u_slot (
      .clk_i   (clock),
      .rst_i   (reset),
      .push_i  (push[g]),
      .req_i   (slot_req[g]),
      .grant_i (grant[g]),
      .full_o  (full[g]),
      .entry_o (slot_entry[g]),
      .urgent_o(urgent[g])
    );
  end

  always_comb begin
    d_d   = d_q;
    rd_d  = rd_q;
    rwe_d = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        d_d   = slot_entry[i].dest;
        rd_d  = slot_entry[i].data;
        rwe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      d_q   <= '0;
      rd_q  <= '0;
      rwe_q <= 1'b0;
    end else begin
      d_q   <= d_d;
      rd_q  <= rd_d;
      rwe_q <= rwe_d;
    end
  end

  assign d    = d_q;
  assign rd   = rd_q;
  assign rwe  = rwe_q;
  assign busy = (|full) || rwe_q;

endmodule
